// File: rtl/graph_pkg.sv
// graph_pkg: shared types and constants for the graph-engine blocks.
// Provides the FP16 type, a few FP16 encodings, the arbiter requester limit
// and rsqrt_entry(), which computes one entry of the 256-entry FP16
// reciprocal-square-root table indexed by the operand's upper byte.
package graph_pkg;

  localparam int RSQRT_ARB_MAX_REQ = 8;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ONE     = 16'h3C00;
  localparam fp16_t FP16_POS_INF = 16'h7C00;
  localparam fp16_t FP16_NEG_INF = 16'hFC00;
  localparam fp16_t FP16_QNAN    = 16'h7E00;

  // Mantissa of 2/sqrt(1+m/4) for an even unbiased exponent, rounded to 10 bits.
  function automatic logic [9:0] even_frac(input logic [1:0] m);
    logic [9:0] f;
    case (m)
      2'd1:    f = 10'h328;
      2'd2:    f = 10'h288;
      2'd3:    f = 10'h20C;
      default: f = 10'h000;
    endcase
    return f;
  endfunction

  // Mantissa of sqrt(2/(1+m/4)) for an odd unbiased exponent, rounded to 10 bits.
  function automatic logic [9:0] odd_frac(input logic [1:0] m);
    logic [9:0] f;
    case (m)
      2'd0:    f = 10'h1A8;
      2'd1:    f = 10'h10F;
      2'd2:    f = 10'h09E;
      2'd3:    f = 10'h047;
      default: f = 10'h000;
    endcase
    return f;
  endfunction

  // rsqrt of the FP16 value whose upper byte is hi (lower byte taken as zero).
  // Every finite positive input maps to a normal result, so only the
  // exponent parity and the two mantissa bits select the result mantissa.
  function automatic fp16_t rsqrt_entry(input logic [7:0] hi);
    logic              sgn;
    logic [4:0]        e;
    logic [1:0]        m;
    logic signed [7:0] ue;
    logic [1:0]        mm;
    logic signed [7:0] r;
    logic [9:0]        frac;
    logic [7:0]        rb;
    fp16_t             res;
    sgn  = hi[7];
    e    = hi[6:2];
    m    = hi[1:0];
    ue   = 8'sd0;
    mm   = 2'd0;
    r    = 8'sd0;
    frac = 10'd0;
    rb   = 8'd0;
    if (e == 5'd31) begin
      res = ((m == 2'd0) && !sgn) ? 16'h0000 : FP16_QNAN;
    end else if ((e == 5'd0) && (m == 2'd0)) begin
      res = sgn ? FP16_NEG_INF : FP16_POS_INF;
    end else if (sgn) begin
      res = FP16_QNAN;
    end else begin
      // Subnormals are renormalised: m*2^-16 becomes (exponent, mantissa).
      if (e == 5'd0) begin
        case (m)
          2'd1:    begin ue = -8'sd16; mm = 2'd0; end
          2'd2:    begin ue = -8'sd15; mm = 2'd0; end
          default: begin ue = -8'sd15; mm = 2'd2; end
        endcase
      end else begin
        ue = $signed({3'b000, e}) - 8'sd15;
        mm = m;
      end
      if (ue[0] == 1'b0) begin
        if (mm == 2'd0) begin
          r    = -(ue >>> 1);
          frac = 10'd0;
        end else begin
          r    = -(ue >>> 1) - 8'sd1;
          frac = even_frac(mm);
        end
      end else begin
        r    = -((ue + 8'sd1) >>> 1);
        frac = odd_frac(mm);
      end
      rb  = r + 8'sd15;
      res = {1'b0, rb[4:0], frac};
    end
    return res;
  endfunction

endpackage

// File: rtl/graph_rsqrt_lut_arb_if.sv
// graph_rsqrt_lut_arb_if: per-requester request/response bus of the shared
// rsqrt LUT arbiter. Lane i occupies bit i of the 1-bit vectors and bits
// [16*i+15:16*i] of the data vectors.
//   master: requester side (drives req_valid, req_data, rsp_ready)
//   slave : arbiter side   (drives req_ready, rsp_valid, rsp_data)
interface graph_rsqrt_lut_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_data;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [NUM_REQ*16-1:0] rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/graph_rsqrt_lut_fp16.sv
// graph_rsqrt_lut_fp16: 256-entry FP16 rsqrt lookup table with one cycle of
// read latency. The output register has no reset; consumers qualify it.
//   clk      : clock
//   addr     : upper byte of the FP16 operand
//   data_out : rsqrt result, valid the cycle after addr is presented
module graph_rsqrt_lut_fp16
  import graph_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  output fp16_t      data_out
);
  fp16_t entry_s;

  // Table contents decoded from the address.
  always_comb begin
    entry_s = rsqrt_entry(addr);
  end

  // Registered table read.
  always_ff @(posedge clk) begin
    data_out <= entry_s;
  end
endmodule

// File: rtl/graph_rsqrt_lut_arb.sv
// graph_rsqrt_lut_arb: round-robin share of one FP16 rsqrt LUT among NUM_REQ
// requesters. One lookup issued per cycle; each result lands in a one-entry
// per-requester response buffer two cycles after the request is accepted.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : request/response lanes (slave side)
//   busy         : a lookup is in flight or any response is pending
//   lookup_count : accepted lookups, wraps at 2^32
module graph_rsqrt_lut_arb
  import graph_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  graph_rsqrt_lut_arb_if.slave bus,
  output logic                 busy,
  output logic [31:0]          lookup_count
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    eligible_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic [ID_W:0]         pick_s;
  logic                  grant_s;
  logic [ID_W-1:0]       grant_id_s;
  logic [7:0]            lut_addr_s;
  fp16_t                 lut_data_s;

  logic                  s1_valid_r;
  logic [ID_W-1:0]       s1_id_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [NUM_REQ-1:0]    rsp_valid_r;
  logic [NUM_REQ*16-1:0] rsp_data_r;
  logic [31:0]           count_r;
  logic [7:0]            addr_hold_r;

  // First eligible index at or after ptr, wrapping; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [ID_W-1:0]    ptr);
    logic            found;
    logic [ID_W-1:0] id;
    int              idx;
    found = 1'b0;
    id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && elig[idx]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
    return {found, id};
  endfunction

  // Eligibility, grant and LUT address selection.
  always_comb begin
    eligible_s  = '0;
    req_ready_s = '0;
    // A lane with a pending or in-flight result is skipped, so its buffer
    // can never be overwritten.
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = bus.req_valid[i] && !rsp_valid_r[i] &&
                      !(s1_valid_r && (s1_id_r == ID_W'(i)));
    end
    pick_s     = rr_pick(eligible_s, rr_ptr_r);
    grant_s    = pick_s[ID_W] && !rst;
    grant_id_s = pick_s[ID_W-1:0];
    if (grant_s) begin
      req_ready_s[grant_id_s] = 1'b1;
      lut_addr_s = bus.req_data[16*int'(grant_id_s)+8 +: 8];
    end else begin
      // Idle address holds to avoid toggling the table.
      lut_addr_s = addr_hold_r;
    end
  end

  // Issue stage, pointer, counter and response buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_id_r     <= '0;
      rr_ptr_r    <= '0;
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
      count_r     <= 32'd0;
      addr_hold_r <= 8'd0;
    end else begin
      s1_valid_r  <= grant_s;
      addr_hold_r <= lut_addr_s;
      if (grant_s) begin
        s1_id_r  <= grant_id_s;
        rr_ptr_r <= (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
        count_r  <= count_r + 32'd1;
      end else begin
        s1_id_r  <= s1_id_r;
        rr_ptr_r <= rr_ptr_r;
        count_r  <= count_r;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s1_valid_r && (s1_id_r == ID_W'(i))) begin
          rsp_valid_r[i]         <= 1'b1;
          rsp_data_r[16*i +: 16] <= lut_data_s;
        end else if (rsp_valid_r[i] && bus.rsp_ready[i]) begin
          rsp_valid_r[i] <= 1'b0;
        end else begin
          rsp_valid_r[i] <= rsp_valid_r[i];
        end
      end
    end
  end

  graph_rsqrt_lut_fp16 u_lut (
    .clk      (clk),
    .addr     (lut_addr_s),
    .data_out (lut_data_s)
  );

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign busy          = s1_valid_r || (|rsp_valid_r);
  assign lookup_count  = count_r;
endmodule

// File: tb/tb_graph_rsqrt_lut_arb.sv
// tb_graph_rsqrt_lut_arb: self-checking bench for graph_rsqrt_lut_arb.
// A transaction-level model (round-robin over requesters without an
// outstanding result, results computed with real arithmetic) predicts every
// output each cycle; directed scenarios add literal checks.
module tb_graph_rsqrt_lut_arb;
  import graph_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [31:0] lookup_count;

  always #5 clk = ~clk;

  graph_rsqrt_lut_arb_if #(.NUM_REQ(N)) bus ();

  graph_rsqrt_lut_arb #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .lookup_count (lookup_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int k);
    real p;
    p = 1.0;
    if (k >= 0) begin
      for (int j = 0; j < k; j++) p = p * 2.0;
    end else begin
      for (int j = 0; j < -k; j++) p = p / 2.0;
    end
    return p;
  endfunction

  // IEEE-style rsqrt of the operand with its low byte cleared, rounded to nearest.
  function automatic logic [15:0] ref_rsqrt(input logic [15:0] d);
    logic       s;
    int         e, m, ex, fr;
    real        x, y;
    logic [4:0] e5;
    logic [9:0] f10;
    s = d[15];
    e = int'(d[14:10]);
    m = int'(d[9:8]);
    if (e == 31) return (m == 0 && !s) ? 16'h0000 : 16'h7E00;
    if (e == 0 && m == 0) return s ? 16'hFC00 : 16'h7C00;
    if (s) return 16'h7E00;
    if (e == 0) x = (real'(m) / 4.0) * pow2(-14);
    else        x = (1.0 + real'(m) / 4.0) * pow2(e - 15);
    y  = 1.0 / $sqrt(x);
    ex = 0;
    while (y >= 2.0) begin y = y / 2.0; ex++; end
    while (y < 1.0)  begin y = y * 2.0; ex--; end
    fr = $rtoi((y - 1.0) * 1024.0 + 0.5);
    if (fr == 1024) begin fr = 0; ex++; end
    e5  = 5'(ex + 15);
    f10 = 10'(fr);
    return {1'b0, e5, f10};
  endfunction

  function automatic int oh_id(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Model state
  logic [N-1:0] m_rv;
  logic [15:0]  m_rd [N];
  logic         m_iv;
  int           m_iid;
  logic [15:0]  m_idat;
  int           m_next;
  logic [31:0]  m_cnt;
  int           wait_cnt [N];
  logic [N-1:0] obs_rdy;

  task automatic model_reset();
    m_rv   = '0;
    m_iv   = 1'b0;
    m_iid  = 0;
    m_idat = 16'h0000;
    m_next = 0;
    m_cnt  = 32'd0;
    for (int i = 0; i < N; i++) begin
      m_rd[i]     = 16'h0000;
      wait_cnt[i] = 0;
    end
  endtask

  // One clock: check outputs at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [N-1:0]   exp_rdy;
    logic [N-1:0]   elig;
    logic [N*16-1:0] exp_data;
    int g, i;
    @(negedge clk);
    g = -1;
    exp_rdy = '0;
    elig = '0;
    for (int k = 0; k < N; k++) begin
      i = (m_next + k) % N;
      elig[i] = bus.req_valid[i] && !m_rv[i] && !(m_iv && m_iid == i);
      if (!rst && g < 0 && elig[i]) g = i;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int j = 0; j < N; j++) exp_data[16*j +: 16] = m_rd[j];
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("rsp_valid", bus.rsp_valid, m_rv);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("busy", busy, m_iv || (|m_rv));
    chk("lookup_count", lookup_count, m_cnt);
    obs_rdy = bus.req_ready;
    if (rst) begin
      model_reset();
    end else begin
      for (int j = 0; j < N; j++) begin
        if (elig[j] && j == g) begin
          chk("wait_bound", (wait_cnt[j] <= N), 1'b1);
          wait_cnt[j] = 0;
        end else if (elig[j]) wait_cnt[j]++;
        else wait_cnt[j] = 0;
      end
      for (int j = 0; j < N; j++) if (m_rv[j] && bus.rsp_ready[j]) m_rv[j] = 1'b0;
      if (m_iv) begin
        m_rv[m_iid] = 1'b1;
        m_rd[m_iid] = m_idat;
      end
      m_iv = (g >= 0);
      if (g >= 0) begin
        m_iid  = g;
        m_idat = ref_rsqrt(bus.req_data[16*g +: 16]);
        m_next = (g + 1) % N;
        m_cnt  = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [15:0] t2_exp [N] = '{16'h3C00, 16'h3800, 16'h7C00, 16'h7E00};
  int seen, others_g, n;
  logic found;

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single requester, 2.0 -> 1/sqrt(2)
    bus.rsp_ready       = '1;
    bus.req_valid       = 4'b0001;
    bus.req_data[15:0]  = 16'h4000;
    step();
    chk("t1_grant", obs_rdy, 4'b0001);
    bus.req_valid = '0;
    chk("t1_rsp_early", bus.rsp_valid[0], 1'b0);
    step();
    chk("t1_rsp_valid", bus.rsp_valid[0], 1'b1);
    chk("t1_rsp_data", bus.rsp_data[15:0], 16'h39A8);
    chk("t1_count", lookup_count, 32'd1);
    step();

    // All four requesters continuously valid
    do_reset();
    bus.req_data  = {16'hBC00, 16'h0000, 16'h4400, 16'h3C00};
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t2_grant", oh_id(obs_rdy), k % N);
      for (int i = 0; i < N; i++) begin
        if (bus.rsp_valid[i]) begin
          chk("t2_result", bus.rsp_data[16*i +: 16], t2_exp[i]);
          seen++;
        end
      end
    end
    chk("t2_results_seen", (seen >= 8), 1'b1);

    // Backpressure on requester 1 holding +inf -> 0
    do_reset();
    bus.req_data  = {16'h3C00, 16'h3C00, 16'h7C00, 16'h3C00};
    bus.req_valid = '1;
    bus.rsp_ready = 4'b1101;
    for (int k = 0; k < 4; k++) step();
    others_g = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_hold_valid", bus.rsp_valid[1], 1'b1);
      chk("t3_hold_data", bus.rsp_data[31:16], 16'h0000);
      chk("t3_no_grant1", obs_rdy[1], 1'b0);
      if (obs_rdy != '0) others_g++;
    end
    chk("t3_others_granted", (others_g >= 8), 1'b1);
    bus.rsp_ready[1] = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 2 * N + 2) begin
      step();
      n++;
      if (obs_rdy[1]) found = 1'b1;
    end
    chk("t3_regrant", found, 1'b1);
    chk("t3_regrant_latency", (n <= N + 1), 1'b1);

    // Low operand bits ignored
    do_reset();
    bus.rsp_ready = '1;
    bus.req_valid = 4'b0100;
    bus.req_data[47:32] = 16'h3C55;
    step();
    bus.req_valid = '0;
    step();
    chk("t4_valid_a", bus.rsp_valid[2], 1'b1);
    chk("t4_low_bits", bus.rsp_data[47:32], 16'h3C00);
    bus.req_valid = 4'b1000;
    bus.req_data[63:48] = 16'h7E01;
    step();
    bus.req_valid = '0;
    step();
    chk("t4_valid_b", bus.rsp_valid[3], 1'b1);
    chk("t4_nan", bus.rsp_data[63:48], 16'h7E00);

    // Reset while a lookup is in flight
    do_reset();
    bus.req_valid = '1;
    step();
    chk("t5_grant", obs_rdy, 4'b0001);
    rst = 1'b1;
    step();
    chk("t5_rdy_in_rst", obs_rdy, 4'b0000);
    rst = 1'b0;
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_rsp_valid", bus.rsp_valid, 4'b0000);
      chk("t5_busy", busy, 1'b0);
      chk("t5_count", lookup_count, 32'd0);
    end
    bus.req_valid = '1;
    step();
    chk("t5_first_grant", obs_rdy, 4'b0001);

    // Random stress; valid is held with stable data until accepted
    do_reset();
    bus.req_valid = '0;
    obs_rdy = '0;
    for (int c = 0; c < 10000; c++) begin
      bus.req_valid = bus.req_valid & ~obs_rdy;
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_data[16*i +: 16] = 16'($urandom);
        end
        bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
